// File: rtl/merge_output_writer.sv
// Sink stage behind the merger tree root. It packs P-record beats into memory lines,
// queues them in a small line FIFO and writes them out as sequential line writes.
module merge_output_writer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned P          = 4,
    parameter int unsigned LINE_WIDTH = 512,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [P*DATA_WIDTH-1:0] i_data,
    input  logic                  i_write,
    output logic                  o_ready,
    input  logic                  i_flush,
    output logic                  o_wr_valid,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [LINE_WIDTH-1:0] o_wr_data,
    input  logic                  i_wr_ready,
    output logic                  o_done,
    output logic [31:0]           o_line_count,
    output logic                  o_overflow
);

    localparam int unsigned BEAT_W     = P * DATA_WIDTH;
    localparam int unsigned BEATS      = LINE_WIDTH / BEAT_W;
    localparam int unsigned LINE_BYTES = LINE_WIDTH / 8;
    localparam int unsigned IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PTR_W      = $clog2(DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_PAD   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic [LINE_WIDTH-1:0] mem_q [DEPTH];
    logic [LINE_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           line_count_q, line_count_d;
    logic                  done_q, done_d;
    logic                  overflow_q, overflow_d;

    logic                  full, empty, ready, accept, pop, push, start_ok;
    logic [LINE_WIDTH-1:0] push_line, beat_line, pad_line;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    // Registers only: the root merger sees no combinational path from its own write.
    assign ready    = (state_q == ST_RUN) && !((idx_q == LAST_IDX) && full);
    assign accept   = i_write && ready;
    assign pop      = !empty && i_wr_ready;
    assign start_ok = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        beat_line = line_q;
        beat_line[int'(idx_q) * BEAT_W +: BEAT_W] = i_data;
        pad_line = line_q;
        pad_line[int'(idx_q) * BEAT_W +: BEAT_W] = {BEAT_W{1'b1}};
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        line_d       = line_q;
        addr_d       = addr_q;
        line_count_d = line_count_q;
        done_d       = done_q;
        overflow_d   = overflow_q;
        push         = 1'b0;
        push_line    = beat_line;

        if (pop) begin
            addr_d       = addr_q + ADDR_WIDTH'(LINE_BYTES);
            line_count_d = line_count_q + 32'd1;
        end

        if (i_write && !ready) begin
            overflow_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d      = ST_RUN;
                    addr_d       = i_base_addr;
                    line_count_d = '0;
                    done_d       = 1'b0;
                    overflow_d   = 1'b0;
                    idx_d        = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    line_d = beat_line;
                    if (idx_q == LAST_IDX) begin
                        push      = 1'b1;
                        push_line = beat_line;
                        idx_d     = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                // Flush is judged on the index after this cycle's beat.
                if (i_flush) begin
                    state_d = (idx_d == '0) ? ST_DRAIN : ST_PAD;
                end
            end
            ST_PAD: begin
                if (idx_q != LAST_IDX) begin
                    line_d = pad_line;
                    idx_d  = idx_q + IDX_W'(1);
                end else if (!full) begin
                    push      = 1'b1;
                    push_line = pad_line;
                    line_d    = pad_line;
                    idx_d     = '0;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (empty) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wr_ptr_q] = push_line;
        end
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            line_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            addr_q       <= '0;
            line_count_q <= '0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            line_q       <= line_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            addr_q       <= addr_d;
            line_count_q <= line_count_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign o_ready      = ready;
    assign o_wr_valid   = !empty;
    assign o_wr_addr    = addr_q;
    assign o_wr_data    = mem_q[rd_ptr_q];
    assign o_done       = done_q;
    assign o_line_count = line_count_q;
    assign o_overflow   = overflow_q;

endmodule
